// File: rtl/aes_pkg.sv
// Shared AES sequencing definitions: round numbering, the last-round helper
// and the per-stage enable bundle consumed by the iterative cipher core.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int RND_W          = 4;

  localparam logic [RND_W-1:0] RND_IDLE  = 4'h0;
  localparam logic [RND_W-1:0] RND_FIRST = 4'h1;

  typedef struct packed {
    logic sb;
    logic sr;
    logic mc;
    logic ar;
    logic ks;
  } aes_enb_t;

  // Round 1 is the initial key add, so the final round sits one past NUM_ROUNDS.
  function automatic logic [RND_W-1:0] rnd_last(input int numRounds);
    return RND_W'(numRounds + 1);
  endfunction

endpackage

// File: rtl/aes_enb_decode.sv
// Combinational round-number to stage-enable decode for the forward AES schedule.
module aes_enb_decode
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic [RND_W-1:0] rndNo,
  output aes_enb_t         enb
);

  localparam logic [RND_W-1:0] RND_FULL_LAST = RND_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0] RND_LAST      = rnd_last(NUM_ROUNDS);

  always_comb begin
    enb = '0;
    if (rndNo == RND_FIRST) begin
      enb.ar = 1'b1;
    end else if ((rndNo > RND_FIRST) && (rndNo <= RND_FULL_LAST)) begin
      enb = '1;
    end else if (rndNo == RND_LAST) begin
      // Final round skips MixColumns.
      enb.sb = 1'b1;
      enb.sr = 1'b1;
      enb.ar = 1'b1;
      enb.ks = 1'b1;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 encryption core: request handshake,
// round counter (which is also the state), stage enables, done pulse and block count.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             accept,
  output logic [RND_W-1:0] rndNo,
  output logic             enbSB,
  output logic             enbSR,
  output logic             enbMC,
  output logic             enbAR,
  output logic             enbKS,
  output logic             done,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [RND_W-1:0] RND_LAST = rnd_last(NUM_ROUNDS);

  if (NUM_ROUNDS + 1 > 15) begin : g_bad_rounds
    $error("aes_round_ctrl: NUM_ROUNDS+1 must not exceed 15");
  end

  aes_enb_t         enb;
  logic [RND_W-1:0] rndNext;
  logic [CNT_W-1:0] cntNext;
  logic             isIdle;
  logic             isLast;

  assign isIdle = (rndNo == RND_IDLE);
  assign isLast = (rndNo == RND_LAST);

  // rndNo is the FSM state: 0 = IDLE, 1..RND_LAST = ROUND.
  always_ff @(posedge clk) begin
    if (rst) begin
      rndNo   <= RND_IDLE;
      blk_cnt <= '0;
    end else begin
      rndNo   <= rndNext;
      blk_cnt <= cntNext;
    end
  end

  always_comb begin
    rndNext = rndNo;
    cntNext = blk_cnt;
    if (accept) begin
      rndNext = RND_FIRST;
    end else if (abort || isIdle || isLast) begin
      rndNext = RND_IDLE;
    end else begin
      rndNext = rndNo + RND_FIRST;
    end
    if (isLast && !abort) begin
      cntNext = blk_cnt + CNT_W'(1);
    end
  end

  // Handshake: start is the request valid, ready the grant; a block transfers on
  // the cycle both are high and abort/rst are low. The requester holds start and
  // its data until that cycle. A final round may accept, giving back-to-back blocks.
  always_comb begin
    ready  = ~rst & (isIdle | isLast);
    accept = start & ready & ~abort & ~rst;
    done   = isLast & ~rst;
    busy   = ~isIdle;
  end

  aes_enb_decode #(
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_enb_decode (
    .rndNo(rndNo),
    .enb  (enb)
  );

  assign enbSB = enb.sb;
  assign enbSR = enb.sr;
  assign enbMC = enb.mc;
  assign enbAR = enb.ar;
  assign enbKS = enb.ks;

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencing controller for the iterative AES-128 encryption core. It accepts one block request at a time through a start/ready handshake and produces the accept pulse, the round number, and the per-stage enables (SubBytes, ShiftRows, MixColumns, AddRoundKey, KeySchedule) that the core consumes. It also flags the single cycle in which the core's cipher_text is valid, and supports back-to-back blocks with no idle gap.

Parameters:
NUM_ROUNDS, 10, number of full AES rounds (AES-128). The final round number is NUM_ROUNDS+1 and must be ≤ 15.
CNT_W, 16, width of the completed-block counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request to encrypt; plain_text and cipher_key are valid at the core inputs while start=1
abort  in  1  synchronous cancel of the block in flight
ready  out  1  controller can take a request this cycle
busy  out  1  a block is in flight (rndNo≠0)
accept  out  1  to core: latch plain_text/cipher_key at this edge
rndNo  out  4  to core: current round, 0 when idle
enbSB  out  1  to core: SubBytes enable
enbSR  out  1  to core: ShiftRows enable
enbMC  out  1  to core: MixColumns enable
enbAR  out  1  to core: AddRoundKey enable
enbKS  out  1  to core: KeySchedule enable
done  out  1  one-cycle pulse; core cipher_text is valid this cycle
blk_cnt  out  CNT_W  number of completed blocks, wraps at 2^CNT_W

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high. While rst=1 the controller returns to IDLE at the next edge: rndNo=0, blk_cnt=0, and all enables, done, busy, accept and ready=0. ready is forced low while rst is high.
- States: IDLE (rndNo=0) and ROUND (rndNo = 1..LAST, where LAST=NUM_ROUNDS+1). The state is encoded by rndNo alone; there is no separate state register.
- ready:
  - 1 in IDLE.
  - 1 when rndNo=LAST.
  - 0 otherwise.
- Handshake:
  - accept = start & ready & ~abort & ~rst. This is combinational, in the same cycle as the handshake.
  - The request source holds its data while start=1. Data is consumed only on the accept cycle.
- Transitions:
  - IDLE with accept: rndNo→1 next cycle.
  - IDLE without accept: stay in IDLE.
  - rndNo in 1..LAST-1: rndNo+1, unconditionally unless abort or rst.
  - rndNo=LAST with accept: rndNo→1 (back-to-back operation, no bubble).
  - rndNo=LAST without accept: rndNo→0.
- Latency: if accept occurs at cycle T, then rndNo=1 at T+1 and done=1 at T+LAST (T+11 by default). Throughput is one block per LAST cycles.
- Enables are combinational decodes of rndNo:
  - rndNo=0: all 0.
  - rndNo=1 (initial key add): enbAR=1; enbSB=enbSR=enbMC=enbKS=0.
  - rndNo 2..NUM_ROUNDS: all five enables = 1.
  - rndNo=LAST: enbSB=enbSR=enbAR=enbKS=1, enbMC=0.
- done = (rndNo==LAST) & ~rst. blk_cnt increments by 1 at the edge ending each done cycle and wraps modulo 2^CNT_W.
- busy = (rndNo≠0).
- Abort:
  - abort=1 in any ROUND cycle: rndNo→0 next cycle, and blk_cnt is not incremented.
  - abort on the LAST cycle: suppresses the increment and blocks any new accept. done still shows 1 that cycle, because the core output is valid.
  - abort in IDLE: no effect except blocking accept.
- Simultaneous events:
  - rst dominates abort, and abort dominates start.
  - start during rndNo 1..LAST-1 is ignored; the requester must hold start.
- Width rule: rndNo never exceeds LAST and never takes the values LAST+1..15. An elaboration check enforces NUM_ROUNDS+1 ≤ 15.

Decomposition:
- Shared package aes_pkg:
  - AES_NUM_ROUNDS=10
  - RND_W=4
  - RND_IDLE=4'h0
  - RND_FIRST=4'h1
  - a function rnd_last(NUM_ROUNDS)
  - a packed struct aes_enb_t {sb, sr, mc, ar, ks}
- Sub-module aes_enb_decode: the combinational rndNo→aes_enb_t decode. It is reused by the future decryption controller with a reversed schedule.
- The counter, handshake and abort logic stay in aes_round_ctrl.

Test Plan:
- Reset then single block: rst for 3 cycles, then start=1 at T with the FIPS-197 key 000102..0f and plaintext 00112233..ff. Required:
  - accept=1 at T only.
  - rndNo=1..11 over T+1..T+11.
  - done=1 at T+11, and the core reports cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a.
  - blk_cnt=1 afterwards.
  - ready=0 over T+1..T+10.
- Enable decode sweep: during one block, sample each round. Required:
  - rndNo=1: AR only.
  - rndNo 2..10: all enables = 1.
  - rndNo=11: MC=0, others 1.
  - idle: all 0.
- Back-to-back: hold start continuously for 3 blocks. Required:
  - accept at T, T+11, T+22.
  - rndNo goes 11→1 without passing through 0.
  - done at T+11, T+22, T+33.
  - blk_cnt=3.
  - each cipher_text matches the software model.
- Abort mid-block: assert abort at rndNo=5. Required:
  - rndNo=0 next cycle; done never asserts; blk_cnt unchanged.
  - a new start next cycle is accepted, and that block completes correctly.
- Abort/start on the last round: at rndNo=11 assert abort and start together. Required:
  - done=1 that cycle; accept=0; blk_cnt unchanged.
  - rndNo=0 next cycle; ready=1.
- Reset mid-block and counter wrap:
  - rst at rndNo=7: all outputs 0 next cycle, and no done.
  - Separately, with CNT_W=2, 5 blocks: blk_cnt sequence 1,2,3,0,1.
